// File: rtl/irq_ctl.sv
// irq_ctl: interrupt and reset front-end for a 65C02 core.
// Aggregates 8 maskable interrupt sources (edge or level per source),
// edge-detects an external NMI and stretches the board reset.
// Software sees four byte registers at BASE..BASE+3 (PEND, MASK, EDGE, VEC)
// with RAM-like synchronous reads: DO/SEL are valid the cycle after the read.
//
// Build option: define IRQC_SYNC_EN to pass irq_src/nmi_src through a
// 2-flop synchroniser (for asynchronous board-level sources). Without it the
// sources are used directly and must be synchronous to clk.
module irq_ctl #(
    parameter logic [15:0] BASE       = 16'hFE00,
    parameter int          RST_CYCLES = 8
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [15:0] AB,
    input  logic [7:0]  DI,
    input  logic        WE,
    output logic [7:0]  DO,
    output logic        SEL,
    input  logic [7:0]  irq_src,
    input  logic        nmi_src,
    output logic        RST,
    output logic        IRQ,
    output logic        NMI
);

    localparam logic [7:0] LP_LAST = 8'(RST_CYCLES - 1);

    logic       r_rst;
    logic [7:0] r_cnt;
    logic [7:0] r_mask;
    logic [7:0] r_edge;
    logic [7:0] r_latch;   // edge-mode pending bits; tracks s in level mode
    logic [7:0] r_h;       // s delayed one cycle, for rising-edge detection
    logic       r_nmi_h;
    logic       r_irq;
    logic       r_nmi;
    logic [7:0] r_do;
    logic       r_sel;

    logic [7:0] w_s;
    logic       w_ns;
    logic [7:0] w_pend;
    logic [7:0] w_act;
    logic [7:0] w_vec;
    logic [7:0] w_rd_data;
    logic [7:0] w_clr;
    logic [7:0] w_rise;
    logic [7:0] w_latch_nxt;
    logic       w_hit;
    logic       w_rd;
    logic       w_wr;

`ifdef IRQC_SYNC_EN
    logic [7:0] r_irq_s1;
    logic [7:0] r_irq_s2;
    logic       r_nmi_s1;
    logic       r_nmi_s2;

    // Two-flop synchronisers for the asynchronous interrupt sources.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_irq_s1 <= 8'h00;
            r_irq_s2 <= 8'h00;
            r_nmi_s1 <= 1'b0;
            r_nmi_s2 <= 1'b0;
        end else begin
            r_irq_s1 <= irq_src;
            r_irq_s2 <= r_irq_s1;
            r_nmi_s1 <= nmi_src;
            r_nmi_s2 <= r_nmi_s1;
        end
    end

    assign w_s  = r_irq_s2;
    assign w_ns = r_nmi_s2;
`else
    assign w_s  = irq_src;
    assign w_ns = nmi_src;
`endif

    // Level-mode bits show the live source; edge-mode bits show the latch.
    assign w_pend = (r_edge & r_latch) | (~r_edge & w_s);
    assign w_act  = w_pend & r_mask;

    assign w_hit = (AB[15:2] == BASE[15:2]);
    assign w_rd  = w_hit & ~WE;
    assign w_wr  = w_hit & WE;

    // Writing 1s to PEND clears edge-mode bits; a same-cycle edge still sets.
    assign w_clr       = (w_wr && AB[1:0] == 2'd0) ? DI : 8'h00;
    assign w_rise      = w_s & ~r_h;
    assign w_latch_nxt = (r_edge & (w_rise | (r_latch & ~w_clr))) | (~r_edge & w_s);

    // Vector of the lowest-numbered pending-and-enabled source.
    always_comb begin
        w_vec = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            if (w_act[i]) w_vec = 8'(i * 2);
        end
    end

    // Register read multiplexer.
    always_comb begin
        w_rd_data = 8'h00;
        case (AB[1:0])
            2'd0:    w_rd_data = w_pend;
            2'd1:    w_rd_data = r_mask;
            2'd2:    w_rd_data = r_edge;
            default: w_rd_data = w_vec;
        endcase
    end

    // Reset stretcher: hold RST for RST_CYCLES clocks after RSTn rises.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_rst <= 1'b1;
            r_cnt <= 8'h00;
        end else if (r_rst) begin
            if (r_cnt == LP_LAST) r_rst <= 1'b0;
            else                  r_cnt <= r_cnt + 8'h01;
        end
    end

    // Source history and pending latch update.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_h     <= 8'h00;
            r_nmi_h <= 1'b0;
            r_latch <= 8'h00;
        end else begin
            r_h     <= w_s;
            r_nmi_h <= w_ns;
            r_latch <= w_latch_nxt;
        end
    end

    // Bus side: MASK/EDGE writes and synchronous register reads.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_mask <= 8'h00;
            r_edge <= 8'h00;
            r_do   <= 8'h00;
            r_sel  <= 1'b0;
        end else begin
            r_sel <= w_rd;
            if (w_rd) r_do <= w_rd_data;
            if (w_wr && AB[1:0] == 2'd1) r_mask <= DI;
            if (w_wr && AB[1:0] == 2'd2) r_edge <= DI;
        end
    end

    // Core-facing IRQ level and one-cycle NMI pulse, both silenced in reset.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_irq <= 1'b0;
            r_nmi <= 1'b0;
        end else begin
            r_irq <= ~r_rst & (|w_act);
            r_nmi <= ~r_rst & w_ns & ~r_nmi_h;
        end
    end

    assign RST = r_rst;
    assign IRQ = r_irq;
    assign NMI = r_nmi;
    assign DO  = r_do;
    assign SEL = r_sel;

endmodule
